// File: rtl/wash_sequencer.sv
// wash_sequencer: washing-machine cycle controller. Runs one soap pass
// (fill, detergent, agitate, drain), RINSE_CNT rinse passes (fill, agitate,
// drain), then a timed spin. Agitate and spin durations come from an internal
// down-counter. Operator abort drains the drum and returns to idle.
//
// Optional build macro WATCHDOG_EN: a counter guards FILL and DRAIN; if the
// level sensor is not seen within FILL_MAX cycles the machine locks in FAULT
// until reset. Without it, error is tied low and FAULT is unreachable.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, door_close   program launch request (level) and door sensor
//   filled, drained     water level sensors
//   detergent_added     dispenser confirmation
//   abort               operator cancel (level)
//   door_lock, fill_valve_on, drain_valve_on, motor_on   actuator drives
//   soap_wash, water_wash, rinse_idx                     pass indication
//   done                one-cycle pulse on normal completion
//   error               sticky fault flag
// All outputs are registered and decoded from the next state.
module wash_sequencer #(
  parameter int unsigned RINSE_CNT   = 2,
  parameter int unsigned TMR_W       = 16,
  parameter int unsigned WASH_TICKS  = 1000,
  parameter int unsigned RINSE_TICKS = 600,
  parameter int unsigned SPIN_TICKS  = 800,
  parameter int unsigned FILL_MAX    = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       door_close,
  input  logic       filled,
  input  logic       drained,
  input  logic       detergent_added,
  input  logic       abort,
  output logic       door_lock,
  output logic       fill_valve_on,
  output logic       drain_valve_on,
  output logic       motor_on,
  output logic       soap_wash,
  output logic       water_wash,
  output logic [2:0] rinse_idx,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    StIdle, StFill, StDetergent, StAgitate, StDrain, StSpin, StDone, StFault
  } state_e;

  // A duration of 0 behaves as 1 so every timed state lasts at least a cycle.
  localparam logic [TMR_W-1:0] WashLoad  = TMR_W'((WASH_TICKS  == 0) ? 1 : WASH_TICKS);
  localparam logic [TMR_W-1:0] RinseLoad = TMR_W'((RINSE_TICKS == 0) ? 1 : RINSE_TICKS);
  localparam logic [TMR_W-1:0] SpinLoad  = TMR_W'((SPIN_TICKS  == 0) ? 1 : SPIN_TICKS);
  localparam logic [2:0]       RinseMax  = 3'(RINSE_CNT);

  state_e           state_q, state_d;
  logic [2:0]       pass_q, pass_d;
  logic             abort_q, abort_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             abort_go;
  logic             wd_fault;

`ifdef WATCHDOG_EN
  localparam int unsigned      FillLim = (FILL_MAX == 0) ? 1 : FILL_MAX;
  localparam int unsigned      WdW     = $clog2(FillLim + 1);
  localparam logic [WdW-1:0]   WdLimit = WdW'(FillLim - 1);
  logic [WdW-1:0] wd_q, wd_d;
`endif

  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    abort_d  = abort_q;
    timer_d  = timer_q;
    wd_fault = 1'b0;
    abort_go = abort && (state_q inside {StFill, StDetergent, StAgitate, StSpin});
`ifdef WATCHDOG_EN
    if ((state_q == StFill && !filled) || (state_q == StDrain && !drained)) begin
      wd_fault = (wd_q == WdLimit);
    end
`endif

    unique case (state_q)
      StIdle: begin
        pass_d  = '0;
        abort_d = 1'b0;
        if (start && door_close) state_d = StFill;
      end
      StFill: begin
        if (filled) state_d = (pass_q == 3'd0) ? StDetergent : StAgitate;
      end
      StDetergent: begin
        if (detergent_added) state_d = StAgitate;
      end
      StAgitate: begin
        if (timer_q <= TMR_W'(1)) state_d = StDrain;
        else timer_d = timer_q - TMR_W'(1);
      end
      StDrain: begin
        if (abort) abort_d = 1'b1;
        if (drained) begin
          // An abort seen in the same cycle as drained still cancels the program.
          if (abort_q || abort) begin
            state_d = StIdle;
          end else if (pass_q < RinseMax) begin
            pass_d  = pass_q + 3'd1;
            state_d = StFill;
          end else begin
            state_d = StSpin;
          end
        end
      end
      StSpin: begin
        if (timer_q <= TMR_W'(1)) state_d = StDone;
        else timer_d = timer_q - TMR_W'(1);
      end
      StDone:  state_d = StIdle;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase

    if (abort_go) begin
      state_d = StDrain;
      abort_d = 1'b1;
    end
    if (wd_fault) state_d = StFault;

    // Timer loads on entry so the first cycle in the state sees the full count.
    if (state_d != state_q) begin
      if (state_d == StAgitate)   timer_d = (pass_d == 3'd0) ? WashLoad : RinseLoad;
      else if (state_d == StSpin) timer_d = SpinLoad;
    end

`ifdef WATCHDOG_EN
    wd_d = '0;
    if ((state_d == state_q) && (state_q inside {StFill, StDrain})) wd_d = wd_q + 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      pass_q         <= '0;
      abort_q        <= 1'b0;
      timer_q        <= '0;
      door_lock      <= 1'b0;
      fill_valve_on  <= 1'b0;
      drain_valve_on <= 1'b0;
      motor_on       <= 1'b0;
      soap_wash      <= 1'b0;
      water_wash     <= 1'b0;
      rinse_idx      <= '0;
      done           <= 1'b0;
`ifdef WATCHDOG_EN
      wd_q           <= '0;
      error          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      pass_q         <= pass_d;
      abort_q        <= abort_d;
      timer_q        <= timer_d;
      door_lock      <= !(state_d inside {StIdle, StDone});
      fill_valve_on  <= (state_d == StFill);
      drain_valve_on <= (state_d inside {StDrain, StSpin});
      motor_on       <= (state_d inside {StAgitate, StSpin});
      soap_wash      <= (pass_d == 3'd0) && !(state_d inside {StIdle, StDone, StFault});
      water_wash     <= (pass_d != 3'd0) && !(state_d inside {StIdle, StDone, StFault});
      rinse_idx      <= pass_d;
      done           <= (state_d == StDone);
`ifdef WATCHDOG_EN
      wd_q           <= wd_d;
      error          <= (state_d == StFault);
`endif
    end
  end

`ifndef WATCHDOG_EN
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: directed scenarios, a phase/elapsed-time model of
// the wash program compared against all outputs every cycle, plus literal
// checks on pass durations, pulses and boundary behaviour.
module tb_wash_sequencer;
  localparam int unsigned RC = 2;
  localparam int unsigned WT = 4;
  localparam int unsigned RT = 3;
  localparam int unsigned ST = 2;
  localparam int unsigned FM = 10;

  logic       clk = 1'b0;
  logic       reset, start, door_close, filled, drained, detergent_added, abort;
  logic       door_lock, fill_valve_on, drain_valve_on, motor_on;
  logic       soap_wash, water_wash, done, error;
  logic [2:0] rinse_idx;

  wash_sequencer #(
    .RINSE_CNT(RC), .TMR_W(16), .WASH_TICKS(WT), .RINSE_TICKS(RT),
    .SPIN_TICKS(ST), .FILL_MAX(FM)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .door_close(door_close),
    .filled(filled), .drained(drained), .detergent_added(detergent_added),
    .abort(abort), .door_lock(door_lock), .fill_valve_on(fill_valve_on),
    .drain_valve_on(drain_valve_on), .motor_on(motor_on), .soap_wash(soap_wash),
    .water_wash(water_wash), .rinse_idx(rinse_idx), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit auto_sense = 1'b0;

  // Program model: which phase we are in, which pass, and how long we have
  // been in the phase.
  typedef enum int {MIdle, MFill, MDet, MAgi, MDrain, MSpin, MDone, MFault} mphase_e;
  mphase_e m_phase = MIdle;
  int      m_pass = 0;
  bit      m_abort = 1'b0;
  int      m_elapsed = 0;

  function automatic int dur(mphase_e p, int pass);
    if (p == MSpin) return ST;
    return (pass == 0) ? WT : RT;
  endfunction

  task automatic model_reset();
    m_phase = MIdle; m_pass = 0; m_abort = 1'b0; m_elapsed = 0;
  endtask

  task automatic model_tick();
    mphase_e nxt = m_phase;
    bit cancel = abort && (m_phase inside {MFill, MDet, MAgi, MSpin});
    bit wd = 1'b0;
`ifdef WATCHDOG_EN
    if ((m_phase == MFill && !filled) || (m_phase == MDrain && !drained))
      wd = (m_elapsed + 1 >= FM);
`endif
    case (m_phase)
      MIdle: begin
        m_pass = 0; m_abort = 1'b0;
        if (start && door_close) nxt = MFill;
      end
      MFill: if (filled) nxt = (m_pass == 0) ? MDet : MAgi;
      MDet:  if (detergent_added) nxt = MAgi;
      MAgi:  if (m_elapsed + 1 >= dur(MAgi, m_pass)) nxt = MDrain;
      MSpin: if (m_elapsed + 1 >= dur(MSpin, m_pass)) nxt = MDone;
      MDrain: begin
        if (drained) begin
          if (m_abort || abort) nxt = MIdle;
          else if (m_pass < RC) begin m_pass++; nxt = MFill; end
          else nxt = MSpin;
        end
        if (abort) m_abort = 1'b1;
      end
      MDone: nxt = MIdle;
      default: ;
    endcase
    if (cancel) begin nxt = MDrain; m_abort = 1'b1; end
    if (wd) nxt = MFault;
    m_elapsed = (nxt == m_phase) ? m_elapsed + 1 : 0;
    m_phase = nxt;
  endtask

  // {door_lock, fill, drain, motor, soap, water, rinse_idx[2:0], done, error}
  function automatic logic [10:0] exp_out();
    bit act = !(m_phase inside {MIdle, MDone, MFault});
    return {m_phase != MIdle && m_phase != MDone, m_phase == MFill,
            m_phase inside {MDrain, MSpin}, m_phase inside {MAgi, MSpin},
            act && m_pass == 0, act && m_pass != 0, 3'(m_pass),
            m_phase == MDone, m_phase == MFault};
  endfunction

  function automatic logic [10:0] act_out();
    return {door_lock, fill_valve_on, drain_valve_on, motor_on, soap_wash, water_wash,
            rinse_idx, done, error};
  endfunction

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: run lengths of agitate and spin, pass at each agitate, done count.
  int agi_len[$];
  int agi_pass[$];
  int spin_len[$];
  int done_cnt = 0;
  int agi_run = 0;
  int spin_run = 0;

  always @(negedge clk) begin
    if (!reset && chk_en) begin
      checks++;
      if (act_out() !== exp_out()) begin
        errors++;
        $display("FAIL outputs: got %b expected %b (lock,fill,drain,motor,soap,water,idx,done,err) t=%0t",
                 act_out(), exp_out(), $time);
      end
    end
    if (motor_on && !drain_valve_on) begin
      if (agi_run == 0) agi_pass.push_back(int'(rinse_idx));
      agi_run++;
    end else if (agi_run != 0) begin
      agi_len.push_back(agi_run); agi_run = 0;
    end
    if (motor_on && drain_valve_on) spin_run++;
    else if (spin_run != 0) begin spin_len.push_back(spin_run); spin_run = 0; end
    if (done) done_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    if (reset) model_reset(); else model_tick();
    @(negedge clk);
    if (auto_sense) begin
      filled          = fill_valve_on;
      drained         = drain_valve_on && !motor_on;
      detergent_added = door_lock && soap_wash && !fill_valve_on && !drain_valve_on && !motor_on;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic run_to_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (done) begin ok = 1'b1; break; end
    end
    lit(name, ok, 1);
  endtask

  int na, ns, nd, n;
  bit ok;

  initial begin
    reset = 1'b1; start = 1'b0; door_close = 1'b1; filled = 1'b0; drained = 1'b0;
    detergent_added = 1'b0; abort = 1'b0;
    model_reset();
    cyc(); cyc();
    lit("reset_outputs_zero", int'(act_out()), 0);
    reset = 1'b0;
    chk_en = 1'b1;
    cyc();
    lit("idle_after_reset", int'(act_out()), 0);

    // Full program, sensors answering one cycle after the request.
    auto_sense = 1'b1;
    na = agi_len.size(); ns = spin_len.size(); nd = done_cnt;
    pulse_start();
    lit("first_fill_soap", int'({fill_valve_on, soap_wash, rinse_idx}), 5'b11000);
    run_to_done("s1_done_seen");
    lit("s1_lock_off_in_done", int'(door_lock), 0);
    cyc(); cyc(); cyc();
    lit("s1_agitate_runs", agi_len.size() - na, 3);
    lit("s1_agi0_len", (agi_len.size() > na) ? agi_len[na] : -1, 4);
    lit("s1_agi1_len", (agi_len.size() > na + 1) ? agi_len[na+1] : -1, 3);
    lit("s1_agi2_len", (agi_len.size() > na + 2) ? agi_len[na+2] : -1, 3);
    lit("s1_pass1_idx", (agi_pass.size() > na + 1) ? agi_pass[na+1] : -1, 1);
    lit("s1_pass2_idx", (agi_pass.size() > na + 2) ? agi_pass[na+2] : -1, 2);
    lit("s1_spin_len", (spin_len.size() > ns) ? spin_len[ns] : -1, 2);
    lit("s1_single_done", done_cnt - nd, 1);

    // Door open: start is ignored.
    door_close = 1'b0; start = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    lit("door_open_idle", int'(act_out()), 0);
    start = 1'b0; door_close = 1'b1;

    // Abort during the pass-1 agitate.
    nd = done_cnt; ns = spin_len.size();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (motor_on && rinse_idx == 3'd1) begin ok = 1'b1; break; end
      cyc();
    end
    lit("s3_reach_pass1_agitate", ok, 1);
    abort = 1'b1; cyc(); abort = 1'b0;
    lit("s3_drain_after_abort", int'({drain_valve_on, motor_on}), 2);
    cyc();
    lit("s3_idle_after_drain", int'({door_lock, fill_valve_on, drain_valve_on, motor_on}), 0);
    for (int i = 0; i < 8; i++) cyc();
    lit("s3_no_refill", int'(fill_valve_on), 0);
    lit("s3_no_done", done_cnt - nd, 0);
    lit("s3_no_spin", spin_len.size() - ns, 0);

    // Reset mid-spin drops actuators before the next edge.
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (motor_on && drain_valve_on) begin ok = 1'b1; break; end
      cyc();
    end
    lit("s4_reach_spin", ok, 1);
    #1 reset = 1'b1;
    #1 lit("s4_async_drop", int'({motor_on, drain_valve_on, door_lock}), 0);
    cyc();
    reset = 1'b0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (door_lock && !fill_valve_on && !motor_on && !drain_valve_on) begin ok = 1'b1; break; end
      cyc();
    end
    lit("s4_detergent_requested", ok, 1);
    lit("s4_pass0_after_reset", int'({soap_wash, rinse_idx}), 4'b1000);
    run_to_done("s4_done_seen");
    cyc(); cyc();

    // Abort in the same cycle as the soap-pass agitate expiry.
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (motor_on) begin ok = 1'b1; break; end
      cyc();
    end
    lit("s6_reach_agitate", ok, 1);
    cyc(); cyc(); cyc();
    lit("s6_still_agitate_cycle4", int'(motor_on), 1);
    abort = 1'b1; cyc(); abort = 1'b0;
    lit("s6_drain", int'({drain_valve_on, motor_on}), 2);
    cyc();
    lit("s6_idle_not_next_pass", int'({door_lock, rinse_idx}), 0);
    for (int i = 0; i < 5; i++) cyc();
    lit("s6_no_refill", int'(fill_valve_on), 0);

`ifdef WATCHDOG_EN
    // Fill never reaches level: fault after FILL_MAX cycles.
    auto_sense = 1'b0; filled = 1'b0; drained = 1'b0; detergent_added = 1'b0;
    pulse_start();
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (fill_valve_on) n++;
      if (error) break;
      cyc();
    end
    lit("wd_fill_cycles", n, FM);
    lit("wd_fault_outputs", int'({error, door_lock, fill_valve_on, drain_valve_on, motor_on}),
        5'b11000);
    pulse_start();
    for (int i = 0; i < 4; i++) cyc();
    lit("wd_start_ignored", int'({error, fill_valve_on}), 2);
    reset = 1'b1; cyc(); reset = 1'b0; cyc();
    lit("wd_cleared_by_reset", int'(act_out()), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Parametrised washing-machine cycle controller: it sequences fill, detergent, agitate and drain passes for one soap wash plus a configurable number of rinses, then a final spin. Agitate and spin durations come from internal timers instead of external timeout strobes. The block also adds operator abort and an optional fill/drain watchdog. It sits between the front-panel/sensor inputs and the valve/motor drivers, replacing the fixed single-rinse controller.

## Interface
- RINSE_CNT, 2, number of rinse passes after the soap wash; legal range 1..7
- TMR_W, 16, width of the internal duration timer
- WASH_TICKS, 1000, agitate cycles in the soap pass
- RINSE_TICKS, 600, agitate cycles in each rinse pass
- SPIN_TICKS, 800, spin cycles
- FILL_MAX, 5000, watchdog limit in FILL/DRAIN (used only with WATCHDOG_EN)

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  level; begin a program when sampled high in IDLE with door_close=1
- door_close  in  1  door sensor, 1 = closed
- filled  in  1  water level reached
- drained  in  1  drum empty
- detergent_added  in  1  detergent dispensed
- abort  in  1  level; operator cancel
- door_lock  out  1  door latch engaged
- fill_valve_on  out  1  inlet valve
- drain_valve_on  out  1  drain pump/valve
- motor_on  out  1  drum motor
- soap_wash  out  1  high during pass 0 (soap pass)
- water_wash  out  1  high during rinse passes
- rinse_idx  out  3  current pass: 0 = soap, 1..RINSE_CNT = rinse
- done  out  1  one-cycle pulse on normal completion
- error  out  1  sticky fault flag

## Operation
- States: IDLE, FILL, DETERGENT, AGITATE, DRAIN, SPIN, DONE, FAULT.
- IDLE:
  - Go to FILL when start & door_close.
  - Pass counter clears to 0; abort flag clears.
- FILL: fill_valve_on=1.
  - On filled, go to DETERGENT if pass==0, else to AGITATE.
- DETERGENT: wait for detergent_added, then go to AGITATE.
- AGITATE: motor_on=1.
  - Timer loads WASH_TICKS in pass 0 and RINSE_TICKS otherwise.
  - Go to DRAIN when the timer expires.
- DRAIN: drain_valve_on=1.
  - On drained with the abort flag set, go to IDLE.
  - On drained with pass < RINSE_CNT, increment pass and go to FILL.
  - On drained otherwise, go to SPIN.
- SPIN: motor_on=1, drain_valve_on=1; timer loads SPIN_TICKS; go to DONE on expiry.
- DONE: done=1 for exactly one cycle, then IDLE.
- FAULT:
  - All actuators off, door_lock=1, error=1.
  - Exits only via reset.
- door_lock=1 in every state except IDLE and DONE.
- soap_wash = (pass==0) & not IDLE/DONE/FAULT. water_wash = (pass!=0) & not IDLE/DONE/FAULT.
- abort: when sampled high in FILL, DETERGENT, AGITATE or SPIN:
  - Set the abort flag and go to DRAIN next cycle.
  - done is never pulsed for an aborted program.
  - abort in DRAIN only sets the flag. abort is ignored in IDLE, DONE and FAULT.
- Priority in one cycle: FAULT condition > abort > normal transition.
- Timer: TMR_W-bit down-counter, loaded on state entry. Expiry = count reaches 1, so the state lasts exactly N cycles. A tick parameter of 0 is treated as 1.
- Pass counter saturates at RINSE_CNT and never wraps.

## Timing
- Moore machine: all outputs decode from the registered state, pass counter and flags; no input reaches an output combinationally.
- Reset (async) forces IDLE, pass=0, abort flag=0, timer=0.
  - Every output is 0 during and after reset until start is sampled.
  - A reset mid-program drops all actuators in the same cycle.
- An input sampled at edge k changes the state and outputs after edge k, one-cycle latency.
- start held high through DONE launches a new program from IDLE two cycles after the done pulse.
- door_close is ignored once the program has left IDLE, because the door is locked.

## Configuration
- WATCHDOG_EN defined:
  - A separate counter runs in FILL and DRAIN and clears on state entry.
  - If filled/drained is not seen within FILL_MAX cycles, go to FAULT. This has priority over abort.
- WATCHDOG_EN undefined:
  - FILL and DRAIN wait indefinitely; error is tied to 0; FAULT is unreachable.
  - FILL_MAX is unused.

## Test plan
- RINSE_CNT=2, WASH_TICKS=4, RINSE_TICKS=3, SPIN_TICKS=2; sensors answer 1 cycle after the request -> passes 0,1,2 observed on rinse_idx; AGITATE lasts 4, 3, 3 cycles; SPIN 2; a single done pulse; door_lock falls in DONE.
- start=1 with door_close=0 -> stays IDLE, all outputs 0.
- abort asserted in pass-1 AGITATE -> DRAIN next cycle; on drained go to IDLE; done never pulses; no SPIN.
- Reset asserted mid-SPIN -> motor_on and drain_valve_on drop before the next edge; the next start begins at pass 0 with DETERGENT requested.
- WATCHDOG_EN, FILL_MAX=10, filled held 0 -> FAULT after 10 FILL cycles, error=1, valves off, door_lock=1; start ignored until reset.
- Same cycle as an AGITATE timer expiry, abort=1 -> DRAIN with the abort flag set, returning to IDLE rather than the next pass.
